// File: rtl/sequence_generator_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding and
// default widths used as parameter defaults by the top and its shift register.
package sequence_generator_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_REP_W = 4;
  localparam int DEF_GAP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable left-shift register with a registered serial MSB output.
// A load presents the top bit of the used field at once and keeps the rest queued.
module seq_shift_reg
  import sequence_generator_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  input  logic [LEN_W-1:0] len,
  output logic             sout
);

  logic [PAT_W-1:0] data;
  logic [PAT_W-1:0] aligned;

  // Push the used field pattern[len-1:0] up against the MSB; upper unused bits fall off.
  assign aligned = din << (LEN_W'(PAT_W) - len);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      sout <= 1'b0;
    end else if (load) begin
      sout <= aligned[PAT_W-1];
      data <= aligned << 1;
    end else if (shift) begin
      sout <= data[PAT_W-1];
      data <= data << 1;
    end else begin
      sout <= 1'b0;
    end
  end

endmodule

// File: rtl/sequence_generator.sv
// Serial bit-pattern transmitter: sends pattern[len-1:0] MSB-first, repeated
// rep times with gap idle cycles between repetitions, then pulses done.
module sequence_generator
  import sequence_generator_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int REP_W = DEF_REP_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] rep,
  input  logic [GAP_W-1:0] gap,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  state_t state, state_n;

  logic [LEN_W-1:0] bit_cnt, bit_cnt_n;
  logic [REP_W-1:0] rep_cnt, rep_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;

  logic [PAT_W-1:0] sh_pattern, sh_pattern_n;
  logic [LEN_W-1:0] sh_len, sh_len_n;
  logic [GAP_W-1:0] sh_gap, sh_gap_n;

  logic [LEN_W-1:0] eff_len;
  logic [REP_W-1:0] eff_rep;

  logic             sr_load;
  logic             sr_shift;
  logic [PAT_W-1:0] sr_din;
  logic [LEN_W-1:0] sr_len;

  assign eff_len = (pat_len == '0 || pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
  assign eff_rep = (rep == '0) ? REP_W'(1) : rep;

  // bit_cnt holds the index of the bit currently on x; rep_cnt the repetitions still owed after this one.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    rep_cnt_n    = rep_cnt;
    gap_cnt_n    = gap_cnt;
    sh_pattern_n = sh_pattern;
    sh_len_n     = sh_len;
    sh_gap_n     = sh_gap;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;
    sr_din       = sh_pattern;
    sr_len       = sh_len;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = SEND;
          sh_pattern_n = pattern;
          sh_len_n     = eff_len;
          sh_gap_n     = gap;
          bit_cnt_n    = eff_len - LEN_W'(1);
          rep_cnt_n    = eff_rep - REP_W'(1);
          sr_load      = 1'b1;
          sr_din       = pattern;
          sr_len       = eff_len;
        end else begin
          state_n = IDLE;
        end
      end
      SEND: begin
        if (bit_cnt != '0) begin
          bit_cnt_n = bit_cnt - LEN_W'(1);
          sr_shift  = 1'b1;
        end else if (rep_cnt != '0) begin
          if (sh_gap != '0) begin
            state_n   = GAP;
            gap_cnt_n = sh_gap - GAP_W'(1);
          end else begin
            bit_cnt_n = sh_len - LEN_W'(1);
            rep_cnt_n = rep_cnt - REP_W'(1);
            sr_load   = 1'b1;
          end
        end else begin
          state_n = DONE;
        end
      end
      GAP: begin
        if (gap_cnt != '0) begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end else begin
          state_n   = SEND;
          bit_cnt_n = sh_len - LEN_W'(1);
          rep_cnt_n = rep_cnt - REP_W'(1);
          sr_load   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with x.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rep_cnt    <= '0;
      gap_cnt    <= '0;
      sh_pattern <= '0;
      sh_len     <= '0;
      sh_gap     <= '0;
      x_valid    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      rep_cnt    <= rep_cnt_n;
      gap_cnt    <= gap_cnt_n;
      sh_pattern <= sh_pattern_n;
      sh_len     <= sh_len_n;
      sh_gap     <= sh_gap_n;
      x_valid    <= (state_n == SEND);
      busy       <= (state_n == SEND) || (state_n == GAP);
      done       <= (state_n == DONE);
    end
  end

  seq_shift_reg #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .load (sr_load),
    .shift(sr_shift),
    .din  (sr_din),
    .len  (sr_len),
    .sout (x)
  );

endmodule
